vga_pixel_engine: RTL and testbench

VGA_PIXEL_ENGINE -- requirements
Module: vga_pixel_engine

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_addr_stepper.sv | 34 +++
 rtl/vga_pixel_engine.sv | 202 ++++++++++++++++++++
 tb/tb_vga_pixel_engine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel engine: bus register offsets,
// command bit positions, FSM/operation encodings and default raster size.
package vga_pkg;

  // Register offsets inside the 7-entry bus window
  localparam logic [7:0] REG_X     = 8'd0;
  localparam logic [7:0] REG_Y     = 8'd1;
  localparam logic [7:0] REG_FG    = 8'd2;
  localparam logic [7:0] REG_BG    = 8'd3;
  localparam logic [7:0] REG_CMD   = 8'd4;
  localparam logic [7:0] REG_PIXEL = 8'd5;
  localparam logic [7:0] REG_LEN   = 8'd6;
  localparam logic [7:0] REG_COUNT = 8'd7;

  // Command register bit positions
  localparam int CMD_WRITE   = 0;
  localparam int CMD_RESTORE = 1;
  localparam int CMD_INVERT  = 2;
  localparam int CMD_RUN     = 3;
  localparam int CMD_AUTO    = 7;

  // Default last visible column/row
  localparam int VGA_X_MAX = 159;
  localparam int VGA_Y_MAX = 119;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RUN  = 3'd4
  } state_e;

  // Single-pixel operation latched when a command is accepted
  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_RESTORE = 2'd1,
    OP_INVERT  = 2'd2
  } op_e;

endpackage

// File: rtl/vga_addr_stepper.sv
// Combinational raster stepper: advances {Y,X} by one pixel, wrapping X at
// X_MAX into the next row and Y at Y_MAX back to the top of the frame.
module vga_addr_stepper #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o
);

  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);

  // Next position: column increment, or row increment with frame wrap
  always_comb begin
    x_o = x_i + X_W'(1);
    y_o = y_i;
    if (x_i == XM) begin
      x_o = '0;
      if (y_i == YM) begin
        y_o = '0;
      end else begin
        y_o = y_i + Y_W'(1);
      end
    end else begin
      x_o = x_i + X_W'(1);
    end
  end

endmodule

// File: rtl/vga_pixel_engine.sv
// VGA pixel engine: CPU-programmed register window driving single-pixel
// read-modify-write commands and horizontal run fills into a frame buffer.
module vga_pixel_engine
  import vga_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         X_W       = 8,
  parameter int         Y_W       = 7,
  parameter int         PIX_W     = 1,
  parameter int         X_MAX     = VGA_X_MAX,
  parameter int         Y_MAX     = VGA_Y_MAX
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [7:0]           BUS_ADDR,
  input  logic [7:0]           BUS_DATA,
  input  logic                 BUS_WE,
  output logic [Y_W+X_W-1:0]   FB_ADDR,
  output logic [PIX_W-1:0]     FB_DIN,
  input  logic [PIX_W-1:0]     FB_DOUT,
  output logic                 FB_WE,
  output logic [15:0]          CONFIG_COLOURS,
  output logic                 BUSY
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [7:0]         fg_q, fg_d;
  logic [7:0]         bg_q, bg_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic [7:0]         len_q, len_d;
  logic [PIX_W-1:0]   saved_q, saved_d;
  logic               auto_q, auto_d;
  logic [8:0]         cnt_q, cnt_d;
  logic               fb_we_q, fb_we_d;
  logic [PIX_W-1:0]   fb_din_q, fb_din_d;
  logic               busy_q, busy_d;

  logic [7:0]         bus_off_s;
  logic               bus_hit_s;
  logic [X_W-1:0]     x_step_s;
  logic [Y_W-1:0]     y_step_s;

  vga_addr_stepper #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_stepper (
    .x_i (x_q),
    .y_i (y_q),
    .x_o (x_step_s),
    .y_o (y_step_s)
  );

  // Window decode: unsigned offset makes addresses below the base miss too
  always_comb begin
    bus_off_s = BUS_ADDR - BASE_ADDR;
    bus_hit_s = BUS_WE && (bus_off_s < REG_COUNT) && (state_q == ST_IDLE);
  end

  // Register writes, command acceptance and FSM next-state/output decode
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    pixel_d  = pixel_q;
    len_d    = len_q;
    saved_d  = saved_q;
    auto_d   = auto_q;
    cnt_d    = cnt_q;
    fb_we_d  = 1'b0;
    fb_din_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus_hit_s) begin
          case (bus_off_s)
            REG_X:     x_d     = BUS_DATA[X_W-1:0];
            REG_Y:     y_d     = BUS_DATA[Y_W-1:0];
            REG_FG:    fg_d    = BUS_DATA;
            REG_BG:    bg_d    = BUS_DATA;
            REG_PIXEL: pixel_d = BUS_DATA[PIX_W-1:0];
            REG_LEN:   len_d   = BUS_DATA;
            REG_CMD: begin
              auto_d = BUS_DATA[CMD_AUTO];
              if (BUS_DATA[CMD_WRITE]) begin
                op_d    = OP_WRITE;
                state_d = ST_RD;
              end else if (BUS_DATA[CMD_RESTORE]) begin
                op_d    = OP_RESTORE;
                state_d = ST_RD;
              end else if (BUS_DATA[CMD_INVERT]) begin
                op_d    = OP_INVERT;
                state_d = ST_RD;
              end else if (BUS_DATA[CMD_RUN]) begin
                // LEN of zero encodes a full 256-pixel run
                cnt_d    = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
                state_d  = ST_RUN;
                fb_we_d  = 1'b1;
                fb_din_d = pixel_q;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // RAM data for {Y,X} is valid now; RESTORE uses the pre-capture SAVED
        saved_d = FB_DOUT;
        state_d = ST_WR;
        fb_we_d = 1'b1;
        case (op_q)
          OP_WRITE:   fb_din_d = pixel_q;
          OP_RESTORE: fb_din_d = saved_q;
          OP_INVERT:  fb_din_d = ~FB_DOUT;
          default:    fb_din_d = pixel_q;
        endcase
      end
      ST_WR: begin
        state_d = ST_IDLE;
        if (auto_q) begin
          x_d = x_step_s;
          y_d = y_step_s;
        end else begin
          x_d = x_q;
          y_d = y_q;
        end
      end
      ST_RUN: begin
        x_d   = x_step_s;
        y_d   = y_step_s;
        cnt_d = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          state_d = ST_IDLE;
        end else begin
          fb_we_d  = 1'b1;
          fb_din_d = pixel_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and register file with asynchronous clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_WRITE;
      x_q      <= '0;
      y_q      <= '0;
      fg_q     <= 8'd0;
      bg_q     <= 8'd0;
      pixel_q  <= '0;
      len_q    <= 8'd0;
      saved_q  <= '0;
      auto_q   <= 1'b0;
      cnt_q    <= 9'd0;
      fb_we_q  <= 1'b0;
      fb_din_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      pixel_q  <= pixel_d;
      len_q    <= len_d;
      saved_q  <= saved_d;
      auto_q   <= auto_d;
      cnt_q    <= cnt_d;
      fb_we_q  <= fb_we_d;
      fb_din_q <= fb_din_d;
      busy_q   <= busy_d;
    end
  end

  assign FB_ADDR        = {y_q, x_q};
  assign FB_DIN         = fb_din_q;
  assign FB_WE          = fb_we_q;
  assign BUSY           = busy_q;
  assign CONFIG_COLOURS = {fg_q, bg_q};

endmodule

// File: tb/tb_vga_pixel_engine.sv
// Self-checking bench for vga_pixel_engine: directed scenarios plus a
// randomized command mix against a raster-index reference model.
module tb_vga_pixel_engine;

  localparam logic [7:0] BASE = 8'hB0;
  localparam int W = 160;
  localparam int H = 120;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BUS_ADDR;
  logic [7:0]  BUS_DATA;
  logic        BUS_WE;
  logic [14:0] FB_ADDR;
  logic [0:0]  FB_DIN;
  logic [0:0]  FB_DOUT;
  logic        FB_WE;
  logic [15:0] CONFIG_COLOURS;
  logic        BUSY;

  logic mem     [0:32767];
  logic ref_mem [0:32767];

  int errors = 0;
  int checks = 0;
  int mx, my, mfg, mbg, mpix, mlen, msaved;

  vga_pixel_engine dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUS_WE(BUS_WE), .FB_ADDR(FB_ADDR), .FB_DIN(FB_DIN), .FB_DOUT(FB_DOUT),
    .FB_WE(FB_WE), .CONFIG_COLOURS(CONFIG_COLOURS), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Frame-buffer RAM: synchronous read, one-cycle latency
  always @(posedge CLK) begin
    if (FB_WE) mem[FB_ADDR] <= FB_DIN[0];
    FB_DOUT <= mem[FB_ADDR];
  end

  function automatic int addr_of(input int x, input int y);
    return y * 256 + x;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mfg = 0; mbg = 0; mpix = 0; mlen = 0; msaved = 0;
  endtask

  // Non-command register write; model follows only for in-window offsets
  task automatic set_reg(input logic [7:0] addr, input logic [7:0] data);
    int off;
    @(negedge CLK);
    BUS_ADDR = addr; BUS_DATA = data; BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    off = int'(addr) - int'(BASE);
    if (off == 0) mx = int'(data);
    else if (off == 1) my = int'(data) % 128;
    else if (off == 2) mfg = int'(data);
    else if (off == 3) mbg = int'(data);
    else if (off == 5) mpix = int'(data) % 2;
    else if (off == 6) mlen = int'(data);
    checks++;
    if (CONFIG_COLOURS !== 16'(mfg * 256 + mbg)) begin
      errors++;
      $display("FAIL colours a=%h: got %h expected %h", addr, CONFIG_COLOURS, 16'(mfg * 256 + mbg));
    end
    checks++;
    if (FB_ADDR !== 15'(addr_of(mx, my))) begin
      errors++;
      $display("FAIL xy_reg a=%h: got %h expected %h", addr, FB_ADDR, 15'(addr_of(mx, my)));
    end
  endtask

  // Issue a CMD write and check every cycle of the resulting operation.
  // poke=1 fires an X write and a CMD write while a RUN is busy.
  task automatic exec_cmd(input logic [7:0] cmd, input bit poke);
    int a, l, idx, exp_din;
    @(negedge CLK);
    BUS_ADDR = BASE + 8'd4; BUS_DATA = cmd; BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    if (cmd[3:0] == 4'd0) begin
      for (int k = 1; k <= 3; k++) begin
        checks++;
        if (BUSY !== 1'b0 || FB_WE !== 1'b0) begin
          errors++;
          $display("FAIL noop cmd=%h k=%0d: got busy=%b we=%b expected 0 0", cmd, k, BUSY, FB_WE);
        end
        @(negedge CLK);
      end
    end else if (cmd[2:0] != 3'd0) begin
      a = addr_of(mx, my);
      if (cmd[0]) exp_din = mpix;
      else if (cmd[1]) exp_din = msaved;
      else exp_din = ref_mem[a] ? 0 : 1;
      for (int k = 1; k <= 3; k++) begin
        checks++;
        if (BUSY !== 1'b1 || FB_WE !== (k == 3) || FB_ADDR !== 15'(a)) begin
          errors++;
          $display("FAIL single cmd=%h k=%0d: got busy=%b we=%b addr=%h expected 1 %b %h",
                   cmd, k, BUSY, FB_WE, FB_ADDR, (k == 3), 15'(a));
        end
        if (k == 3) begin
          checks++;
          if (FB_DIN !== 1'(exp_din)) begin
            errors++;
            $display("FAIL single_din cmd=%h: got %b expected %0d", cmd, FB_DIN, exp_din);
          end
        end
        @(negedge CLK);
      end
      msaved = ref_mem[a] ? 1 : 0;
      ref_mem[a] = (exp_din != 0);
      if (cmd[7]) begin
        idx = (my * W + mx + 1) % (W * H);
        mx = idx % W; my = idx / W;
      end
      checks++;
      if (BUSY !== 1'b0 || FB_WE !== 1'b0 || FB_ADDR !== 15'(addr_of(mx, my))) begin
        errors++;
        $display("FAIL single_end cmd=%h: got busy=%b we=%b addr=%h expected 0 0 %h",
                 cmd, BUSY, FB_WE, FB_ADDR, 15'(addr_of(mx, my)));
      end
    end else begin
      l = (mlen == 0) ? 256 : mlen;
      idx = my * W + mx;
      for (int k = 1; k <= l; k++) begin
        a = addr_of(idx % W, idx / W);
        checks++;
        if (BUSY !== 1'b1 || FB_WE !== 1'b1 || FB_DIN !== 1'(mpix) || FB_ADDR !== 15'(a)) begin
          errors++;
          $display("FAIL run k=%0d: got busy=%b we=%b din=%b addr=%h expected 1 1 %0d %h",
                   k, BUSY, FB_WE, FB_DIN, FB_ADDR, mpix, 15'(a));
        end
        ref_mem[a] = (mpix != 0);
        idx = (idx + 1) % (W * H);
        if (poke && k == 1) begin
          BUS_ADDR = BASE; BUS_DATA = 8'd77; BUS_WE = 1'b1;
        end else if (poke && k == 2) begin
          BUS_ADDR = BASE + 8'd4; BUS_DATA = 8'h01; BUS_WE = 1'b1;
        end else begin
          BUS_WE = 1'b0;
        end
        @(negedge CLK);
      end
      BUS_WE = 1'b0;
      mx = idx % W; my = idx / W;
      checks++;
      if (BUSY !== 1'b0 || FB_WE !== 1'b0 || FB_ADDR !== 15'(addr_of(mx, my))) begin
        errors++;
        $display("FAIL run_end: got busy=%b we=%b addr=%h expected 0 0 %h",
                 BUSY, FB_WE, FB_ADDR, 15'(addr_of(mx, my)));
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 8'd0; BUS_DATA = 8'd0;
    repeat (3) @(negedge CLK);
    model_reset();
    checks++;
    if (FB_WE !== 1'b0 || BUSY !== 1'b0 || FB_ADDR !== 15'd0 || FB_DIN !== 1'b0 || CONFIG_COLOURS !== 16'd0) begin
      errors++;
      $display("FAIL reset: got we=%b busy=%b addr=%h din=%b col=%h expected all zero",
               FB_WE, BUSY, FB_ADDR, FB_DIN, CONFIG_COLOURS);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_write();
    set_reg(BASE, 8'd200);          // stored unchanged beyond X_MAX
    set_reg(BASE, 8'd5);
    set_reg(BASE + 8'd1, 8'd3);
    set_reg(BASE + 8'd5, 8'd1);
    set_reg(BASE + 8'd2, 8'hA5);
    set_reg(BASE + 8'd3, 8'h3C);
    exec_cmd(8'h01, 1'b0);
  endtask

  task automatic test_invert_restore();
    exec_cmd(8'h04, 1'b0);          // pixel 1 -> 0, SAVED = 1
    exec_cmd(8'h02, 1'b0);          // restore writes 1
  endtask

  task automatic test_run_wrap();
    set_reg(BASE, 8'd158);
    set_reg(BASE + 8'd1, 8'd119);
    set_reg(BASE + 8'd6, 8'd4);
    set_reg(BASE + 8'd5, 8'd1);
    exec_cmd(8'h08, 1'b0);
  endtask

  task automatic test_auto_inc();
    set_reg(BASE, 8'd159);
    set_reg(BASE + 8'd1, 8'd10);
    exec_cmd(8'h81, 1'b0);
  endtask

  task automatic test_busy_ignore();
    set_reg(BASE, 8'd30);
    set_reg(BASE + 8'd1, 8'd40);
    set_reg(BASE + 8'd6, 8'd6);
    exec_cmd(8'h08, 1'b1);
    set_reg(BASE + 8'd5, 8'd0);
    exec_cmd(8'h0F, 1'b0);          // only WRITE, no auto-increment
    set_reg(BASE + 8'hFF, 8'd9);    // below the window
    set_reg(BASE + 8'd7, 8'd9);     // just above the window
  endtask

  task automatic test_reset_abort();
    set_reg(BASE, 8'd20);
    set_reg(BASE + 8'd1, 8'd7);
    @(negedge CLK);
    BUS_ADDR = BASE + 8'd4; BUS_DATA = 8'h04; BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    checks++;
    if (FB_WE !== 1'b0 || BUSY !== 1'b0 || FB_ADDR !== 15'd0 || FB_DIN !== 1'b0 || CONFIG_COLOURS !== 16'd0) begin
      errors++;
      $display("FAIL abort_async: got we=%b busy=%b addr=%h din=%b col=%h expected all zero",
               FB_WE, BUSY, FB_ADDR, FB_DIN, CONFIG_COLOURS);
    end
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (FB_WE !== 1'b0 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet k=%0d: got we=%b busy=%b expected 0 0", k, FB_WE, BUSY);
      end
      @(negedge CLK);
    end
    set_reg(BASE + 8'd5, 8'd1);
    exec_cmd(8'h01, 1'b0);
  endtask

  task automatic test_random();
    int r;
    logic [7:0] a;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: set_reg(BASE, 8'($urandom_range(0, 159)));
        1: set_reg(BASE + 8'd1, 8'($urandom_range(0, 119)));
        2: set_reg(BASE + 8'd2, 8'($urandom));
        3: set_reg(BASE + 8'd3, 8'($urandom));
        4: set_reg(BASE + 8'd5, 8'($urandom));
        5: set_reg(BASE + 8'd6, 8'($urandom_range(0, 12)));
        6: begin
          a = 8'($urandom);
          if (a >= BASE && a < BASE + 8'd7) a = 8'h10;
          set_reg(a, 8'($urandom));
        end
        default: exec_cmd(8'($urandom), 1'b0);
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 1'b0;
      ref_mem[i] = 1'b0;
    end
    FB_DOUT = 1'b0;
    test_reset();
    test_write();
    test_invert_restore();
    test_run_wrap();
    test_auto_inc();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
